// File: rtl/sonyimx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sonyimx_pkg : shared types and constants for the IMX timing gen     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package sonyimx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEAD   = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HBLANK = 3'd3,
    ST_TAIL   = 3'd4,
    ST_VBLANK = 3'd5
  } state_t;

  // Smallest gaps that keep the downstream SAV/EAV windows from overlapping
  localparam int unsigned MIN_LINE_ACTIVE = 9;
  localparam int unsigned MIN_HBLANK      = 8;
  localparam int unsigned MIN_FVAL_LEAD   = 8;
  localparam int unsigned MIN_FVAL_TAIL   = 5;
  localparam int unsigned MIN_VBLANK      = 1;
  localparam int unsigned MIN_FRAME_LINES = 1;

  localparam logic [1:0] PAT_HRAMP = 2'b00;
  localparam logic [1:0] PAT_LINE  = 2'b01;
  localparam logic [1:0] PAT_FRAME = 2'b10;
  localparam logic [1:0] PAT_ZERO  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/pattern_gen_sonyimx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pattern_gen_sonyimx : registered test-pattern pixel source          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pattern_gen_sonyimx
  import sonyimx_pkg::*;
#(
  parameter int DATA_WIDTH  = 10,
  parameter int CHANNEL_NUM = 8,
  parameter int CNT_W       = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic [CNT_W-1:0]                  col,
  input  logic [CNT_W-1:0]                  line,
  input  logic [CNT_W-1:0]                  frame,
  input  logic [1:0]                        sel,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] pix_data
);

  logic [DATA_WIDTH*CHANNEL_NUM-1:0] w_pix;

  // Channel 0 sits in the least-significant lane
  for (genvar ch = 0; ch < CHANNEL_NUM; ch++) begin : g_ch
    logic [DATA_WIDTH-1:0] w_ramp;
    assign w_ramp = DATA_WIDTH'(col) * DATA_WIDTH'(CHANNEL_NUM) + DATA_WIDTH'(ch);
    assign w_pix[ch*DATA_WIDTH +: DATA_WIDTH] =
        (sel == PAT_HRAMP) ? w_ramp :
        (sel == PAT_LINE)  ? DATA_WIDTH'(line) :
        (sel == PAT_FRAME) ? DATA_WIDTH'(frame) : '0;
  end : g_ch

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_data <= '0;
    end else begin
      pix_data <= en ? w_pix : '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/timing_gen_sonyimx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | timing_gen_sonyimx : fval/lval/pixel frame sequencer for IMX model  |
// | Optional pattern source: define TIMING_GEN_PATTERN_EN   Rev 1.0     |
// +--------------------------------------------------------------------+
module timing_gen_sonyimx
  import sonyimx_pkg::*;
#(
  parameter int DATA_WIDTH  = 10,
  parameter int CHANNEL_NUM = 8,
  parameter int CNT_W       = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_enable,
  input  logic                              i_trigger_mode,
  input  logic                              i_trigger,
  input  logic [CNT_W-1:0]                  iv_line_active,
  input  logic [CNT_W-1:0]                  iv_line_hblank,
  input  logic [CNT_W-1:0]                  iv_frame_lines,
  input  logic [CNT_W-1:0]                  iv_fval_lead,
  input  logic [CNT_W-1:0]                  iv_fval_tail,
  input  logic [CNT_W-1:0]                  iv_vblank,
  input  logic [1:0]                        iv_pattern_sel,
  output logic                              o_fval,
  output logic                              o_lval,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
  output logic                              o_frame_done,
  output logic                              o_trig_miss,
  output logic                              o_busy
);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_load;
  logic [CNT_W-1:0] r_line, r_col, r_frame;
  logic [CNT_W-1:0] r_sh_active, r_sh_hblank, r_sh_lines, r_sh_tail, r_sh_vblank;
  logic             w_cnt_done, w_lead_entry, w_state_chg;
  logic             r_fval, r_lval, r_fval_d, r_frame_done, r_trig_miss;

  function automatic logic [CNT_W-1:0] clamp_min(input logic [CNT_W-1:0] v, input int unsigned m);
    return (v < CNT_W'(m)) ? CNT_W'(m) : v;
  endfunction

  assign w_cnt_done   = (r_cnt == '0);
  assign w_lead_entry = (w_next == ST_LEAD) && (r_state != ST_LEAD);
  assign w_state_chg  = (w_next != r_state);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_enable && (!i_trigger_mode || i_trigger)) w_next = ST_LEAD;
      ST_LEAD:   if (w_cnt_done) w_next = ST_ACTIVE;
      ST_ACTIVE: if (w_cnt_done) w_next = ST_HBLANK;
      ST_HBLANK: if (w_cnt_done)
                   w_next = (r_line == r_sh_lines - CNT_W'(1)) ? ST_TAIL : ST_ACTIVE;
      ST_TAIL:   if (w_cnt_done) w_next = ST_VBLANK;
      ST_VBLANK: if (w_cnt_done)
                   w_next = (i_enable && !i_trigger_mode) ? ST_LEAD : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // LEAD is loaded from the live inputs because the shadows latch on that same edge
  always_comb begin
    w_load = CNT_W'(1);
    case (w_next)
      ST_LEAD:   w_load = clamp_min(iv_fval_lead, MIN_FVAL_LEAD);
      ST_ACTIVE: w_load = r_sh_active;
      ST_HBLANK: w_load = r_sh_hblank;
      ST_TAIL:   w_load = r_sh_tail;
      ST_VBLANK: w_load = r_sh_vblank;
      default:   w_load = CNT_W'(1);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_line      <= '0;
      r_col       <= '0;
      r_frame     <= '0;
      r_sh_active <= '0;
      r_sh_hblank <= '0;
      r_sh_lines  <= '0;
      r_sh_tail   <= '0;
      r_sh_vblank <= '0;
    end else begin
      r_state <= w_next;
      if (w_state_chg)      r_cnt <= w_load - CNT_W'(1);
      else if (!w_cnt_done) r_cnt <= r_cnt - CNT_W'(1);

      if (w_lead_entry) begin
        r_sh_active <= clamp_min(iv_line_active, MIN_LINE_ACTIVE);
        r_sh_hblank <= clamp_min(iv_line_hblank, MIN_HBLANK);
        r_sh_lines  <= clamp_min(iv_frame_lines, MIN_FRAME_LINES);
        r_sh_tail   <= clamp_min(iv_fval_tail, MIN_FVAL_TAIL);
        r_sh_vblank <= clamp_min(iv_vblank, MIN_VBLANK);
      end

      if (w_lead_entry)                                    r_line <= '0;
      else if (r_state == ST_HBLANK && w_next == ST_ACTIVE) r_line <= r_line + CNT_W'(1);

      if (r_state != ST_ACTIVE && w_next == ST_ACTIVE) r_col <= '0;
      else if (r_state == ST_ACTIVE)                   r_col <= r_col + CNT_W'(1);

      if (r_state == ST_TAIL && w_next == ST_VBLANK) r_frame <= r_frame + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fval       <= 1'b0;
      r_lval       <= 1'b0;
      r_fval_d     <= 1'b0;
      r_frame_done <= 1'b0;
      r_trig_miss  <= 1'b0;
    end else begin
      r_fval       <= (r_state != ST_IDLE) && (r_state != ST_VBLANK);
      r_lval       <= (r_state == ST_ACTIVE);
      r_fval_d     <= r_fval;
      r_frame_done <= r_fval_d & ~r_fval;
      r_trig_miss  <= i_trigger_mode & i_trigger & (r_state != ST_IDLE);
    end
  end

  assign o_fval       = r_fval;
  assign o_lval       = r_lval;
  assign o_frame_done = r_frame_done;
  assign o_trig_miss  = r_trig_miss;
  assign o_busy       = (r_state != ST_IDLE);

`ifdef TIMING_GEN_PATTERN_EN
  logic [1:0] r_sh_sel;
  logic       w_pix_en;

  assign w_pix_en = (r_state == ST_ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_sh_sel <= '0;
    else if (w_lead_entry) r_sh_sel <= iv_pattern_sel;
  end

  pattern_gen_sonyimx #(
    .DATA_WIDTH  (DATA_WIDTH),
    .CHANNEL_NUM (CHANNEL_NUM),
    .CNT_W       (CNT_W)
  ) u_pattern (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (w_pix_en),
    .col      (r_col),
    .line     (r_line),
    .frame    (r_frame),
    .sel      (r_sh_sel),
    .pix_data (ov_pix_data)
  );
`else
  logic w_unused_pattern;
  assign w_unused_pattern = ^{iv_pattern_sel, r_col, r_frame};
  assign ov_pix_data      = '0;
`endif

endmodule
`default_nettype wire
